// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing controller: default 800x600@72 timing,
// grid geometry used by the cell tracker, and the "no cell" index value.
package vga_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_HSIZE = 800;
  localparam int DEF_HFP   = 856;
  localparam int DEF_HSP   = 976;
  localparam int DEF_HMAX  = 1040;
  localparam int DEF_VSIZE = 600;
  localparam int DEF_VFP   = 637;
  localparam int DEF_VSP   = 643;
  localparam int DEF_VMAX  = 666;
  localparam int DEF_HSPP  = 1;
  localparam int DEF_VSPP  = 1;

  localparam int GRID_ORG = 50;
  localparam int CELL     = 50;
  localparam int NCELL    = 10;

  localparam logic [3:0] CELL_NONE = 4'd15;

  function automatic logic [CNT_W-1:0] to_cnt(input int v);
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/grid_axis_tracker.sv
// One axis of the grid cell tracker: follows a position counter with an
// offset-within-cell and cell index, using compares only (no divide/multiply).
module grid_axis_tracker
  import vga_pkg::*;
#(
  parameter int ORG   = GRID_ORG,
  parameter int PITCH = CELL,
  parameter int N     = NCELL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 wrap,
  input  logic [CNT_W-1:0]     pos,
  output logic [3:0]           idx,
  output logic                 inr,
  output logic                 hit
);

  localparam logic [CNT_W-1:0] ORG_C    = to_cnt(ORG);
  localparam logic [CNT_W-1:0] END_C    = to_cnt(ORG + N * PITCH);
  localparam logic [CNT_W-1:0] LAST_OFF = to_cnt(PITCH - 1);
  localparam logic [3:0]       LAST_IDX = 4'(N - 1);

  logic             act, act_nx;
  logic [CNT_W-1:0] off, off_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             at_end;

  // Next state is derived from the position the counter is about to take,
  // so the registered state always matches the position shown next cycle.
  always_comb begin
    act_nx = act;
    off_nx = off;
    cnt_nx = cnt;
    if (wrap) begin
      act_nx = (ORG == 0);
      off_nx = '0;
      cnt_nx = '0;
    end else if (inc) begin
      if (pos + 1'b1 == ORG_C) begin
        act_nx = 1'b1;
        off_nx = '0;
        cnt_nx = '0;
      end else if (act) begin
        if (off == LAST_OFF) begin
          off_nx = '0;
          if (cnt == LAST_IDX) begin
            act_nx = 1'b0;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end else begin
          off_nx = off + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act <= 1'b0;
      off <= '0;
      cnt <= '0;
    end else begin
      act <= act_nx;
      off <= off_nx;
      cnt <= cnt_nx;
    end
  end

  // The closing boundary line sits one past the last cell.
  assign at_end = (pos == END_C);
  assign idx    = act ? cnt : CELL_NONE;
  assign inr    = act | at_end;
  assign hit    = (act && off == '0) | at_end;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with optional grid cell tracker.
// Define VGA_CELL_TRACK_EN to build the cell tracker; otherwise cell outputs are constant.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int HSIZE    = DEF_HSIZE,
  parameter int HFP      = DEF_HFP,
  parameter int HSP      = DEF_HSP,
  parameter int HMAX     = DEF_HMAX,
  parameter int VSIZE    = DEF_VSIZE,
  parameter int VFP      = DEF_VFP,
  parameter int VSP      = DEF_VSP,
  parameter int VMAX     = DEF_VMAX,
  parameter int HSPP     = DEF_HSPP,
  parameter int VSPP     = DEF_VSPP,
  parameter int GRID_ORG = vga_pkg::GRID_ORG,
  parameter int CELL     = vga_pkg::CELL,
  parameter int NCELL    = vga_pkg::NCELL
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] hdata,
  output logic [11:0] vdata,
  output logic        hsync,
  output logic        vsync,
  output logic        data_enable,
  output logic        frame_start,
  output logic [3:0]  cell_col,
  output logic [3:0]  cell_row,
  output logic        in_grid,
  output logic        on_line
);

  localparam logic [CNT_W-1:0] HSIZE_C = to_cnt(HSIZE);
  localparam logic [CNT_W-1:0] HFP_C   = to_cnt(HFP);
  localparam logic [CNT_W-1:0] HSP_C   = to_cnt(HSP);
  localparam logic [CNT_W-1:0] HLAST   = to_cnt(HMAX - 1);
  localparam logic [CNT_W-1:0] VSIZE_C = to_cnt(VSIZE);
  localparam logic [CNT_W-1:0] VFP_C   = to_cnt(VFP);
  localparam logic [CNT_W-1:0] VSP_C   = to_cnt(VSP);
  localparam logic [CNT_W-1:0] VLAST   = to_cnt(VMAX - 1);
  localparam logic             HPOL    = 1'(HSPP);
  localparam logic             VPOL    = 1'(VSPP);

  logic hwrap;
  logic vwrap;

  assign hwrap = (hdata == HLAST);
  assign vwrap = (vdata == VLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdata <= '0;
      vdata <= '0;
    end else begin
      hdata <= hwrap ? '0 : hdata + 12'd1;
      if (hwrap) begin
        vdata <= vwrap ? '0 : vdata + 12'd1;
      end
    end
  end

  assign hsync       = (hdata >= HFP_C && hdata < HSP_C) ? HPOL : ~HPOL;
  assign vsync       = (vdata >= VFP_C && vdata < VSP_C) ? VPOL : ~VPOL;
  assign data_enable = (hdata < HSIZE_C) && (vdata < VSIZE_C);
  assign frame_start = (hdata == '0) && (vdata == '0);

`ifdef VGA_CELL_TRACK_EN
  logic hinr, vinr, hhit, vhit;

  grid_axis_tracker #(
    .ORG   (GRID_ORG),
    .PITCH (CELL),
    .N     (NCELL)
  ) u_hcell (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wrap  (hwrap),
    .pos   (hdata),
    .idx   (cell_col),
    .inr   (hinr),
    .hit   (hhit)
  );

  // Vertical axis steps once per line and restarts on the frame wrap.
  grid_axis_tracker #(
    .ORG   (GRID_ORG),
    .PITCH (CELL),
    .N     (NCELL)
  ) u_vcell (
    .clk   (clk),
    .reset (reset),
    .inc   (hwrap),
    .wrap  (hwrap & vwrap),
    .pos   (vdata),
    .idx   (cell_row),
    .inr   (vinr),
    .hit   (vhit)
  );

  assign in_grid = hinr & vinr;
  assign on_line = in_grid & (hhit | vhit);
`else
  assign cell_col = CELL_NONE;
  assign cell_row = CELL_NONE;
  assign in_grid  = 1'b0;
  assign on_line  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: arithmetic reference model checked every cycle,
// plus directed literal checks at hand-picked pixels and a mid-frame reset.
module tb_vga_timing_ctrl;

  localparam int HMAX = 1040;
  localparam int VMAX = 666;
  localparam int GO   = 50;
  localparam int CL   = 50;
  localparam int GE   = GO + 10 * CL;
  localparam longint FRAME = 64'd692640;
`ifdef VGA_CELL_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] hdata, vdata;
  logic        hsync, vsync, data_enable, frame_start, in_grid, on_line;
  logic [3:0]  cell_col, cell_row;

  int total = 0;
  int bad   = 0;
  longint tick;

  vga_timing_ctrl dut (
    .clk         (clk),
    .reset       (rst),
    .hdata       (hdata),
    .vdata       (vdata),
    .hsync       (hsync),
    .vsync       (vsync),
    .data_enable (data_enable),
    .frame_start (frame_start),
    .cell_col    (cell_col),
    .cell_row    (cell_row),
    .in_grid     (in_grid),
    .on_line     (on_line)
  );

  always #5 clk = ~clk;

  // Cycles elapsed since reset release; position follows by plain division.
  always @(posedge clk or posedge rst) begin
    if (rst) tick <= 0;
    else     tick <= tick + 1;
  end

  function automatic logic [37:0] model(input longint tk);
    int h, v;
    logic hs, vs, de, fs, ig, ol;
    logic [3:0] cc, cr;
    h  = int'(tk % HMAX);
    v  = int'((tk / HMAX) % VMAX);
    hs = (h >= 856 && h < 976);
    vs = (v >= 637 && v < 643);
    de = (h < 800 && v < 600);
    fs = (h == 0 && v == 0);
    cc = 4'd15;
    cr = 4'd15;
    ig = 1'b0;
    ol = 1'b0;
    if (TRK) begin
      if (h >= GO && h < GE) cc = 4'((h - GO) / CL);
      if (v >= GO && v < GE) cr = 4'((v - GO) / CL);
      ig = (h >= GO && h <= GE && v >= GO && v <= GE);
      ol = ig && (((h - GO) % CL) == 0 || ((v - GO) % CL) == 0);
    end
    return {12'(h), 12'(v), hs, vs, de, fs, cc, cr, ig, ol};
  endfunction

  // Per-cycle comparison; stops counting once enough faults are reported.
  always @(negedge clk) begin
    logic [37:0] exp_v, act_v;
    if (bad < 20) begin
      exp_v = model(tick);
      act_v = {hdata, vdata, hsync, vsync, data_enable, frame_start,
               cell_col, cell_row, in_grid, on_line};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model_cycle tick=%0d actual=%h required=%h", tick, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_hdata"}, int'(hdata), 0);
    chk({pfx, "_vdata"}, int'(vdata), 0);
    chk({pfx, "_hsync"}, int'(hsync), 0);
    chk({pfx, "_vsync"}, int'(vsync), 0);
    chk({pfx, "_de"}, int'(data_enable), 1);
    chk({pfx, "_fs"}, int'(frame_start), 1);
    chk({pfx, "_col"}, int'(cell_col), 15);
    chk({pfx, "_row"}, int'(cell_row), 15);
    chk({pfx, "_ingrid"}, int'(in_grid), 0);
    chk({pfx, "_online"}, int'(on_line), 0);
  endtask

  initial begin
    int fs_n = 0, hs_n = 0, vs_n = 0;
    longint fs_t0 = -1, fs_t1 = -1;
    int hs_first = -1, hs_last = -1, vs_first = -1, vs_last = -1;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    @(posedge clk);
    #1 rst = 1'b0;

    for (longint t = 0; t <= FRAME; t++) begin
      @(negedge clk);
      if (frame_start) begin
        fs_n++;
        if (fs_n == 1) fs_t0 = t;
        else           fs_t1 = t;
      end
      if (t < HMAX && hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(t);
        hs_last = int'(t);
      end
      if (t < FRAME && (t % HMAX) == 0 && vsync) begin
        vs_n++;
        if (vs_first < 0) vs_first = int'(t / HMAX);
        vs_last = int'(t / HMAX);
      end
      case (t)
        64'd0: begin
          chk("first_hdata", int'(hdata), 0);
          chk("first_fs", int'(frame_start), 1);
        end
        64'd1039: begin
          chk("eol_hdata", int'(hdata), 1039);
          chk("eol_vdata", int'(vdata), 0);
        end
        64'd1040: begin
          chk("wrap_hdata", int'(hdata), 0);
          chk("wrap_vdata", int'(vdata), 1);
        end
        64'd78050: begin  // (50,75)
          chk("p50_75_ingrid", int'(in_grid), TRK ? 1 : 0);
          chk("p50_75_online", int'(on_line), TRK ? 1 : 0);
          chk("p50_75_col", int'(cell_col), TRK ? 0 : 15);
          chk("p50_75_row", int'(cell_row), TRK ? 0 : 15);
        end
        64'd124949: begin  // (149,120)
          chk("p149_120_col", int'(cell_col), TRK ? 1 : 15);
          chk("p149_120_row", int'(cell_row), TRK ? 1 : 15);
          chk("p149_120_online", int'(on_line), 0);
        end
        64'd312551: begin  // (551,300)
          chk("p551_300_ingrid", int'(in_grid), 0);
          chk("p551_300_online", int'(on_line), 0);
          chk("p551_300_col", int'(cell_col), 15);
          chk("p551_300_row", int'(cell_row), TRK ? 5 : 15);
        end
        64'd572550: begin  // (550,550)
          chk("p550_550_ingrid", int'(in_grid), TRK ? 1 : 0);
          chk("p550_550_online", int'(on_line), TRK ? 1 : 0);
          chk("p550_550_col", int'(cell_col), 15);
          chk("p550_550_row", int'(cell_row), 15);
        end
        default: ;
      endcase
    end

    chk("fs_count", fs_n, 2);
    chk("fs_first_cycle", int'(fs_t0), 0);
    chk("fs_second_cycle", int'(fs_t1), 692640);
    chk("hsync_cols", hs_n, 120);
    chk("hsync_first_col", hs_first, 856);
    chk("hsync_last_col", hs_last, 975);
    chk("vsync_lines", vs_n, 6);
    chk("vsync_first_line", vs_first, 637);
    chk("vsync_last_line", vs_last, 642);

    // Advance into the second frame to pixel (500,300), then reset mid-frame.
    repeat (312500) @(negedge clk);
    chk("pre_rst_hdata", int'(hdata), 500);
    chk("pre_rst_vdata", int'(vdata), 300);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_hdata", int'(hdata), 0);
    chk("restart_vdata", int'(vdata), 0);
    chk("restart_fs", int'(frame_start), 1);
    repeat (5) @(negedge clk);
    chk("restart5_hdata", int'(hdata), 5);
    chk("restart5_fs", int'(frame_start), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
